// File: rtl/bin_to_digit_scan_pkg.sv
// Shared constants and types for the binary-to-digit scan display path.
// Also reused by the seven-segment decoder.
package bin_to_digit_scan_pkg;

    localparam int NUM_DIGITS  = 4;
    localparam int BCD_W       = 4;
    localparam int BIN_W       = 14;
    localparam int MAX_DISPLAY = 9999;
    localparam int DISP_W      = NUM_DIGITS * BCD_W;

    typedef enum logic {
        IDLE,
        CONVERT
    } state_t;

    function automatic logic [BIN_W-1:0] saturate(
        input logic [BIN_W-1:0] v
    );
        if (v > BIN_W'(MAX_DISPLAY))
            return BIN_W'(MAX_DISPLAY);
        return v;
    endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Iterative shift-add-3 converter, one iteration per clock.
// done pulses combinationally during the last iteration with bcd valid.
module bin_to_bcd
    import bin_to_digit_scan_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BIN_W-1:0]  bin,
    output logic              done,
    output logic [DISP_W-1:0] bcd,
    output logic              ovf
);

    logic [BIN_W-1:0]  bin_q;
    logic [BIN_W-1:0]  bin_n;
    logic [DISP_W-1:0] bcd_q;
    logic [DISP_W-1:0] bcd_n;
    logic [DISP_W-1:0] adj;
    logic [3:0]        cnt;
    logic              running;
    logic              ovf_q;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[i*BCD_W +: BCD_W] >= 4'd5)
                adj[i*BCD_W +: BCD_W] = bcd_q[i*BCD_W +: BCD_W] + 4'd3;
        end
        bcd_n = {adj[DISP_W-2:0], bin_q[BIN_W-1]};
        bin_n = {bin_q[BIN_W-2:0], 1'b0};
    end

    assign done = running && (cnt == 4'(BIN_W - 1));
    assign bcd  = bcd_n;
    assign ovf  = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt     <= '0;
            running <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (start) begin
            bin_q   <= saturate(bin);
            ovf_q   <= (bin > BIN_W'(MAX_DISPLAY));
            bcd_q   <= '0;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            bin_q <= bin_n;
            bcd_q <= bcd_n;
            cnt   <= cnt + 4'd1;
            if (done)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/bin_to_digit_scan.sv
// Converts a binary reading to four BCD digits and time-multiplexes them
// onto an active-low digit-select bus for a registered segment decoder.
module bin_to_digit_scan
    import bin_to_digit_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] value,
    input  logic             load,
    output logic             busy,
    output logic             ovf,
    output logic [BCD_W-1:0] digit_value,
    output logic [3:0]       digit_sel
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    state_t            state;
    state_t            state_n;
    logic              start;
    logic              done;
    logic [DISP_W-1:0] bcd;
    logic              cvt_ovf;
    logic [DISP_W-1:0] display;
    logic [CNT_W-1:0]  scan_cnt;
    logic [1:0]        idx;
    logic [1:0]        idx_d;

    assign start = (state == IDLE) && load;

    bin_to_bcd u_cvt (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (value),
        .done  (done),
        .bcd   (bcd),
        .ovf   (cvt_ovf)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (load) state_n = CONVERT;
            CONVERT: if (done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            ovf     <= 1'b0;
            display <= '0;
        end else begin
            state <= state_n;
            busy  <= (state_n == CONVERT);
            // Whole result lands at once so the scan never shows a partial value.
            if (done) begin
                display <= bcd;
                ovf     <= cvt_ovf;
            end
        end
    end

    // Select lags value by one cycle to line up with the decoder register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt    <= '0;
            idx         <= '0;
            idx_d       <= '0;
            digit_value <= '0;
            digit_sel   <= 4'b1111;
        end else begin
            if (scan_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            idx_d       <= idx;
            digit_value <= display[{idx, 2'b00} +: BCD_W];
            digit_sel   <= ~(4'b0001 << idx_d);
        end
    end

endmodule

// File: tb/tb_bin_to_digit_scan.sv
// Self-checking bench: directed scenarios plus random loads against a
// cycle-level behavioural model of conversion timing and digit scanning.
module tb_bin_to_digit_scan;

    localparam int RD = 4;

    logic        clk;
    logic        rst;
    logic [13:0] value;
    logic        load;
    logic        busy;
    logic        ovf;
    logic [3:0]  digit_value;
    logic [3:0]  digit_sel;

    int checks;
    int failures;

    int m_left;
    int m_val;
    int m_ovf_pend;
    int m_ovf;
    int m_disp[4];
    int k;

    bin_to_digit_scan #(.REFRESH_DIV(RD)) dut (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .load        (load),
        .busy        (busy),
        .ovf         (ovf),
        .digit_value (digit_value),
        .digit_sel   (digit_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_left     = 0;
        m_val      = 0;
        m_ovf_pend = 0;
        m_ovf      = 0;
        for (int i = 0; i < 4; i++) m_disp[i] = 0;
        k = 0;
    endtask

    task automatic step();
        logic       ld;
        int         v;
        logic [3:0] exp_dv;
        logic [3:0] exp_sel;
        int         sel_i;
        int         div;
        ld = load;
        v  = int'(value);
        @(posedge clk);
        exp_dv = 4'(m_disp[(k / RD) % 4]);
        sel_i  = (k == 0) ? 0 : ((k - 1) / RD) % 4;
        exp_sel = ~(4'b0001 << sel_i);
        if (m_left == 0) begin
            if (ld) begin
                m_val      = (v > 9999) ? 9999 : v;
                m_ovf_pend = (v > 9999) ? 1 : 0;
                m_left     = 14;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                div = 1;
                for (int i = 0; i < 4; i++) begin
                    m_disp[i] = (m_val / div) % 10;
                    div = div * 10;
                end
                m_ovf = m_ovf_pend;
            end
        end
        k++;
        #1;
        chk("busy", 16'(busy), 16'(m_left > 0));
        chk("ovf", 16'(ovf), 16'(m_ovf));
        chk("digit_value", 16'(digit_value), 16'(exp_dv));
        chk("digit_sel", 16'(digit_sel), 16'(exp_sel));
        chk("one_low", 16'($countones(~digit_sel)), 16'd1);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_ovf", 16'(ovf), 16'd0);
        chk("rst_dv", 16'(digit_value), 16'd0);
        chk("rst_sel", 16'(digit_sel), 16'hf);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_sel", 16'(digit_sel), 16'hf);
        chk("rst_hold_busy", 16'(busy), 16'd0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic convert(input int v, input int wait_cycles);
        value = 14'(v);
        load  = 1'b1;
        step();
        load  = 1'b0;
        repeat (wait_cycles) step();
    endtask

    initial begin
        int busy_len;
        checks   = 0;
        failures = 0;
        value    = '0;
        load     = 1'b0;
        model_reset();
        apply_reset();
        repeat (5) step();

        value = 14'd1234;
        load  = 1'b1;
        step();
        busy_len = (busy === 1'b1) ? 1 : 0;
        load  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy === 1'b1) busy_len++;
        end
        chk("busy_len_1234", 16'(busy_len), 16'd14);
        repeat (20) step();

        convert(12000, 36);
        convert(7, 36);

        value = 14'd321;
        load  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) value = 14'd8765;
            step();
        end
        load = 1'b0;
        repeat (34) step();

        value = 14'd5678;
        load  = 1'b1;
        step();
        load  = 1'b0;
        repeat (7) step();
        #2;
        apply_reset();
        repeat (24) step();

        convert(0, 36);
        convert(9999, 36);
        convert(10000, 20);
        convert(16383, 20);

        for (int n = 0; n < 12; n++) begin
            int gap;
            value = 14'($urandom_range(0, 16383));
            load  = 1'b1;
            step();
            gap = int'($urandom_range(10, 30));
            for (int j = 0; j < gap; j++) begin
                load  = 1'($urandom_range(0, 1));
                value = 14'($urandom_range(0, 16383));
                step();
            end
        end
        load = 1'b0;
        repeat (40) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
